// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the memory access unit: default geometry and FSM encoding.
package mem_access_unit_pkg;

  localparam int DEPTH_DEFAULT = 50;
  localparam int AW_DEFAULT    = 6;
  localparam int DW_DEFAULT    = 8;

  // The error counter stops here instead of wrapping back to zero.
  localparam logic [7:0] ERR_COUNT_MAX = 8'hFF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } state_t;

endpackage

// File: rtl/mem_access_unit.sv
// Memory access unit: takes one load/store request at a time from the core,
// drives a single-cycle strobe to a registered data memory and returns one
// response. Out-of-range addresses never reach the memory and are counted.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int AW    = AW_DEFAULT,
  parameter int DW    = DW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic [DW-1:0] resp_rdata,
  output logic          resp_err,
  output logic          mem_write,
  output logic          mem_read,
  output logic [AW-1:0] mem_address,
  output logic [DW-1:0] mem_data_in,
  input  logic [DW-1:0] mem_data_out,
  output logic [7:0]    err_count
);

  // One extra bit so a DEPTH equal to 2^AW still compares correctly.
  localparam logic [AW:0] DEPTH_LIMIT = (AW+1)'(DEPTH);

  state_t state;
  logic   write_q;
  logic   addr_err;

  // Range check of the incoming address; only consulted on the accept edge.
  always_comb begin
    addr_err = ({1'b0, req_addr} >= DEPTH_LIMIT);
  end

  // Sequencer with every output registered. mem_address and mem_data_in double
  // as the latched request so they are already stable when the strobe rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      write_q     <= 1'b0;
      req_ready   <= 1'b1;
      resp_valid  <= 1'b0;
      resp_rdata  <= '0;
      resp_err    <= 1'b0;
      mem_write   <= 1'b0;
      mem_read    <= 1'b0;
      mem_address <= '0;
      mem_data_in <= '0;
      err_count   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            req_ready   <= 1'b0;
            write_q     <= req_write;
            mem_address <= req_addr;
            mem_data_in <= req_wdata;
            if (addr_err) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else begin
              state     <= ACCESS;
              mem_write <= req_write;
              mem_read  <= !req_write;
            end
          end
        end

        ACCESS: begin
          mem_write <= 1'b0;
          mem_read  <= 1'b0;
          if (write_q) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
          end else begin
            state <= CAPTURE;
          end
        end

        CAPTURE: begin
          state      <= RESP;
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= mem_data_out;
        end

        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            if (resp_err && (err_count != ERR_COUNT_MAX)) begin
              err_count <= err_count + 8'd1;
            end
          end
        end

        default: begin
          state      <= IDLE;
          req_ready  <= 1'b1;
          resp_valid <= 1'b0;
          mem_write  <= 1'b0;
          mem_read   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter DEPTH, default 50, number of valid data-memory words.
REQ-002 SHALL have parameter AW, default 6, address width.
REQ-003 SHALL have parameter DW, default 8, data width.
REQ-004 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port req_valid  input  1  core request present.
REQ-007 SHALL have port req_ready  output  1  unit accepts a request this cycle.
REQ-008 SHALL have port req_write  input  1  1 = store, 0 = load.
REQ-009 SHALL have port req_addr  input  AW  word address.
REQ-010 SHALL have port req_wdata  input  DW  store data.
REQ-011 SHALL have port resp_valid  output  1  response present.
REQ-012 SHALL have port resp_ready  input  1  core consumes response.
REQ-013 SHALL have port resp_rdata  output  DW  load data (0 for stores and errors).
REQ-014 SHALL have port resp_err  output  1  address >= DEPTH, no memory access made.
REQ-015 SHALL have port mem_write  output  1  write strobe to the data memory.
REQ-016 SHALL have port mem_read  output  1  read strobe to the data memory.
REQ-017 SHALL have port mem_address  output  AW  memory address.
REQ-018 SHALL have port mem_data_in  output  DW  memory write data.
REQ-019 SHALL have port mem_data_out  input  DW  memory read data, registered in memory, valid one edge after mem_read.
REQ-020 SHALL have port err_count  output  8  saturating count of error responses.

Function
REQ-021 SHALL implement FSM states IDLE, ACCESS, CAPTURE, RESP.
REQ-022 SHALL assert req_ready only in IDLE; request accepted on edge where req_valid && req_ready.
REQ-023 On accept, SHALL latch write, addr, wdata into internal registers; req_* ignored until next IDLE.
REQ-024 On accept with req_addr >= DEPTH, SHALL go IDLE->RESP with resp_err=1, resp_rdata=0, mem strobes never asserted.
REQ-025 On accept with valid address, SHALL go IDLE->ACCESS.
REQ-026 In ACCESS, SHALL assert exactly one of mem_write (store) or mem_read (load) for one cycle, mem_address/mem_data_in from latched values.
REQ-027 ACCESS store SHALL go to RESP; ACCESS load SHALL go to CAPTURE.
REQ-028 In CAPTURE, SHALL register mem_data_out into resp_rdata and go to RESP.
REQ-029 In RESP, SHALL hold resp_valid=1 and stable resp_rdata/resp_err until resp_ready=1, then go IDLE.
REQ-030 Latency from accept edge to resp_valid: error 1 cycle, store 2 cycles, load 3 cycles.
REQ-031 req_valid during RESP with resp_ready=1 SHALL NOT be accepted that cycle; accepted next cycle in IDLE earliest.
REQ-032 mem_write and mem_read SHALL never be high simultaneously and SHALL be 0 outside ACCESS.
REQ-033 err_count SHALL increment on each RESP->IDLE transition with resp_err=1 and saturate at 255.
REQ-034 Address DEPTH-1 (49) SHALL be treated as valid; DEPTH (50) through 2^AW-1 as error.

Reset
REQ-035 rst_n low SHALL immediately force state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, mem_write=0, mem_read=0, mem_address=0, mem_data_in=0, err_count=0.
REQ-036 Reset asserted mid-operation SHALL abandon the transaction with no response; memory contents are not restored.

Structure
REQ-037 Shared package SHALL hold DEPTH/AW/DW defaults and the FSM state encoding.
REQ-038 No sub-module required; single module with FSM plus datapath registers.

Verification
REQ-039 Store addr 5 data 0xA5, then load addr 5 -> store resp_valid 2 cycles after accept, load resp_rdata=0xA5 3 cycles after accept, resp_err=0.
REQ-040 Load addr 50 -> resp_valid 1 cycle after accept, resp_err=1, resp_rdata=0, mem_read/mem_write never high, err_count=1.
REQ-041 Load addr 49 after store 0x3C -> resp_rdata=0x3C, resp_err=0.
REQ-042 Hold resp_ready=0 for 4 cycles in RESP with req_valid=1 -> response stable, req_ready=0, no new memory strobe.
REQ-043 Assert rst_n=0 during ACCESS of a load -> mem_read drops immediately, resp_valid stays 0, state IDLE after release.
REQ-044 256 error requests plus one more -> err_count stays 255.
